// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion blocks: digit width, the
// reverse double-dabble correction constants, FSM state codes and a helper
// that sizes a binary result for a given number of decimal digits.
package bcd_pkg;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_ADJUST = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        ADJUST = ST_ADJUST,
        DONE   = ST_DONE
    } bcd_state_e;

    // Smallest width w with 2^w >= 10^digits.
    function automatic int bcd_bin_width(input int digits);
        longint unsigned limit;
        int              width;
        limit = 1;
        for (int i = 0; i < digits; i++) begin
            limit = limit * 10;
        end
        width = 0;
        for (int w = 63; w >= 0; w--) begin
            if ((64'd1 << w) >= limit) begin
                width = w;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Start/done handshake bundle between a requester and bcd_to_binary.
interface bcd_to_binary_if #(
    parameter int DECIMAL_DIGITS = 3,
    parameter int OUTPUT_WIDTH   = 10
);
    import bcd_pkg::*;

    logic                                  start_i;
    logic [DECIMAL_DIGITS*BCD_DIGIT_W-1:0] bcd_i;
    logic [OUTPUT_WIDTH-1:0]               binary_o;
    logic                                  done_o;
    logic                                  busy_o;
    logic                                  error_o;

    modport master (
        output start_i, bcd_i,
        input  binary_o, done_o, busy_o, error_o
    );

    modport slave (
        input  start_i, bcd_i,
        output binary_o, done_o, busy_o, error_o
    );

endinterface

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter (reverse double dabble).
// Each pass shifts {bcd, bin} right by one bit, then corrects one BCD digit
// per cycle (subtract 3 from any digit >= 8). No correction follows the
// final shift. Optional macro BCD_INVALID_CHECK_EN adds a sticky flag that
// reports captured digits above 9 on error_o; without it error_o is 0.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int DECIMAL_DIGITS = 3,
    parameter int OUTPUT_WIDTH   = 10
) (
    input  logic           clk_i,
    input  logic           rst_i,
    bcd_to_binary_if.slave bus
);

    localparam int BCD_W = DECIMAL_DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = $clog2(OUTPUT_WIDTH + 1);
    localparam int IDX_W = $clog2(DECIMAL_DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(OUTPUT_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(DECIMAL_DIGITS - 1);

    bcd_state_e              state;
    logic [BCD_W-1:0]        bcd_reg;
    logic [OUTPUT_WIDTH-1:0] bin_reg;
    logic [OUTPUT_WIDTH-1:0] binary_q;
    logic [CNT_W-1:0]        shift_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic                    done_q;
    logic                    busy_q;
    logic [BCD_DIGIT_W-1:0]  cur_digit;
    logic [BCD_DIGIT_W-1:0]  adj_digit;

    // Select the digit under correction and compute its adjusted value.
    always_comb begin
        cur_digit = '0;
        for (int d = 0; d < DECIMAL_DIGITS; d++) begin
            if (digit_idx == IDX_W'(d)) begin
                cur_digit = bcd_reg[d*BCD_DIGIT_W +: BCD_DIGIT_W];
            end
        end
        adj_digit = (cur_digit >= BCD_ADJ_THRESH) ? (cur_digit - BCD_ADJ_VAL) : cur_digit;
    end

`ifdef BCD_INVALID_CHECK_EN
    logic any_invalid;
    logic err_flag;
    logic error_q;

    // Flag any input digit above 9 so it can be latched on acceptance.
    always_comb begin
        any_invalid = 1'b0;
        for (int d = 0; d < DECIMAL_DIGITS; d++) begin
            if (bus.bcd_i[d*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) begin
                any_invalid = 1'b1;
            end
        end
    end

    assign bus.error_o = error_q;
`else
    assign bus.error_o = 1'b0;
`endif

    // Conversion FSM with registered handshake outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            bcd_reg   <= '0;
            bin_reg   <= '0;
            binary_q  <= '0;
            shift_cnt <= '0;
            digit_idx <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef BCD_INVALID_CHECK_EN
            err_flag  <= 1'b0;
            error_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_i) begin
                        bcd_reg   <= bus.bcd_i;
                        bin_reg   <= '0;
                        shift_cnt <= '0;
                        digit_idx <= '0;
                        busy_q    <= 1'b1;
                        state     <= SHIFT;
`ifdef BCD_INVALID_CHECK_EN
                        err_flag  <= any_invalid;
                        error_q   <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    {bcd_reg, bin_reg} <= {1'b0, bcd_reg, bin_reg[OUTPUT_WIDTH-1:1]};
                    if (shift_cnt == LAST_SHIFT) begin
                        shift_cnt <= '0;
                        state     <= DONE;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                        digit_idx <= '0;
                        state     <= ADJUST;
                    end
                end
                ADJUST: begin
                    for (int d = 0; d < DECIMAL_DIGITS; d++) begin
                        if (digit_idx == IDX_W'(d)) begin
                            bcd_reg[d*BCD_DIGIT_W +: BCD_DIGIT_W] <= adj_digit;
                        end
                    end
                    if (digit_idx == LAST_DIGIT) begin
                        state <= SHIFT;
                    end else begin
                        digit_idx <= digit_idx + 1'b1;
                    end
                end
                DONE: begin
                    binary_q <= bin_reg;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
`ifdef BCD_INVALID_CHECK_EN
                    error_q  <= err_flag;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.binary_o = binary_q;
    assign bus.done_o   = done_q;
    assign bus.busy_o   = busy_q;

endmodule
